// File: rtl/wfunc_pkg.sv
// Shared register map and state encodings for the window-function block and its APB loader.
package wfunc_pkg;
  localparam int CTRL_IDX         = 0;
  localparam int STATUS_IDX       = 1;
  localparam int CTRL_SOFT_RST    = 0;
  localparam int CTRL_CHANGE      = 8;
  localparam int STATUS_STATE_LSB = 8;
  localparam int STATUS_STATE_MSB = 9;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    BUSY = 2'b10
  } wfunc_state_e;

  typedef enum logic [2:0] {
    LD_IDLE, LD_RST, LD_POLL, LD_COEF, LD_ARM, LD_CHK, LD_DONE
  } ld_state_e;

  function automatic logic [31:0] ctrl_word(input int bitpos);
    return 32'(1) << bitpos;
  endfunction
endpackage

// File: rtl/wfunc_apb_xfer.sv
// Two-phase APB initiator: a request accepted while idle or in ACCESS starts SETUP next cycle.
module wfunc_apb_xfer #(
  parameter int APB_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [APB_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);
  logic can_issue;

  assign can_issue = !psel || penable;
  assign ack       = psel && penable;
  assign rdata     = prdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (req && can_issue) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= wr;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end
endmodule

// File: rtl/wfunc_apb_loader.sv
// Loads a window coefficient stream into the window-function block over APB:
// soft reset, wait for IDLE, write all words, optionally change state, confirm status.
module wfunc_apb_loader
  import wfunc_pkg::*;
#(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE - 1) + 2 + 1,
  parameter int POLL_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);
  localparam int IW = $clog2(FFT_SIZE);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [APB_AW-1:0] CTRL_ADDR   = APB_AW'((FFT_SIZE + CTRL_IDX) * 4);
  localparam logic [APB_AW-1:0] STATUS_ADDR = APB_AW'((FFT_SIZE + STATUS_IDX) * 4);
  localparam logic [IW-1:0]     LAST_IDX    = IW'(FFT_SIZE - 1);

  ld_state_e         state, state_nxt;
  logic              arm_q, arm_nxt, err_q, err_nxt, fin_q, fin_nxt;
  logic              busy_q, done_q, tready_q;
  logic [IW-1:0]     idx_q, idx_nxt;
  logic [PW-1:0]     poll_q, poll_nxt;
  logic              req, wr, ack, hs;
  logic [APB_AW-1:0] addr;
  logic [31:0]       wdata, rdata;
  logic [1:0]        st;
  logic              unused_rdata;

  assign st           = rdata[STATUS_STATE_MSB:STATUS_STATE_LSB];
  assign unused_rdata = ^{rdata[31:STATUS_STATE_MSB+1], rdata[STATUS_STATE_LSB-1:0]};
  assign hs           = tready_q && s_tvalid;

  wfunc_apb_xfer #(.APB_AW(APB_AW)) u_xfer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata)
  );

  // Each state issues its follow-on request in the ACCESS cycle so transfers run back-to-back.
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_q;
    err_nxt   = err_q;
    fin_nxt   = fin_q;
    idx_nxt   = idx_q;
    poll_nxt  = poll_q;
    req       = 1'b0;
    wr        = 1'b0;
    addr      = STATUS_ADDR;
    wdata     = '0;
    case (state)
      LD_IDLE, LD_DONE: begin
        state_nxt = LD_IDLE;
        if (start) begin
          state_nxt = LD_RST;
          arm_nxt   = arm;
          err_nxt   = 1'b0;
          req       = 1'b1;
          wr        = 1'b1;
          addr      = CTRL_ADDR;
          wdata     = ctrl_word(CTRL_SOFT_RST);
        end
      end
      LD_RST: begin
        if (ack) begin
          state_nxt = LD_POLL;
          poll_nxt  = '0;
          req       = 1'b1;
        end
      end
      LD_POLL: begin
        if (ack) begin
          if (st == IDLE) begin
            state_nxt = LD_COEF;
            idx_nxt   = '0;
            fin_nxt   = 1'b0;
          end else if (poll_q == PW'(POLL_MAX - 1)) begin
            err_nxt   = 1'b1;
            state_nxt = LD_DONE;
          end else begin
            poll_nxt = poll_q + PW'(1);
            req      = 1'b1;
          end
        end
      end
      LD_COEF: begin
        if (hs) begin
          req     = 1'b1;
          wr      = 1'b1;
          addr    = APB_AW'({idx_q, 2'b00});
          wdata   = s_tdata;
          idx_nxt = idx_q + IW'(1);
          if (s_tlast != (idx_q == LAST_IDX)) begin
            err_nxt = 1'b1;
            fin_nxt = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            fin_nxt = 1'b1;
          end
        end
        // A framing error ends the load after its word is written, skipping CHANGE STATE.
        if (ack && fin_q) begin
          if (err_q) begin
            state_nxt = LD_DONE;
          end else if (arm_q) begin
            state_nxt = LD_ARM;
            req       = 1'b1;
            wr        = 1'b1;
            addr      = CTRL_ADDR;
            wdata     = ctrl_word(CTRL_CHANGE);
          end else begin
            state_nxt = LD_CHK;
            req       = 1'b1;
          end
        end
      end
      LD_ARM: begin
        if (ack) begin
          state_nxt = LD_CHK;
          req       = 1'b1;
        end
      end
      LD_CHK: begin
        if (ack) begin
          state_nxt = LD_DONE;
          if (arm_q ? !(st == WAIT || st == BUSY) : (st != IDLE)) err_nxt = 1'b1;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LD_IDLE;
      arm_q    <= 1'b0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
      idx_q    <= '0;
      poll_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      arm_q    <= arm_nxt;
      err_q    <= err_nxt;
      fin_q    <= fin_nxt;
      idx_q    <= idx_nxt;
      poll_q   <= poll_nxt;
      busy_q   <= !(state_nxt inside {LD_IDLE, LD_DONE});
      done_q   <= (state_nxt == LD_DONE);
      // Ready is low in the SETUP cycle after a handshake and once the final word is taken.
      tready_q <= (state_nxt == LD_COEF) && !fin_nxt && !hs;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign s_tready = tready_q;
endmodule
